dmem_copy_engine: RTL

Block-copy master for the data memory's single port. It drives the `a`/`wd`/`we` side and samples `rd`, moving `len` consecutive words from `src` to `dst` after a one-cycle `start` pulse. It sits beside the MIPS core. The top-level arbiter muxes the dmem port between the core and this engine using `busy`, and stalls the engine through `gnt`.

---
 rtl/dmem_copy_engine_pkg.sv | 15 +
 rtl/dmem_copy_engine.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine_pkg.sv
// Shared definitions for the dmem block-copy engine:
// word width, memory depth and FSM state encodings.
package dmem_copy_engine_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 65536;

    typedef enum logic [1:0] {
        CP_IDLE = 2'd0,
        CP_RD   = 2'd1,
        CP_WR   = 2'd2,
        CP_DONE = 2'd3
    } cp_state_t;

endpackage

// File: rtl/dmem_copy_engine.sv
// Block-copy master for the single dmem port, stalled by the arbiter grant.
// Optional running checksum of written words: define DMEM_COPY_CSUM_EN.
module dmem_copy_engine
    import dmem_copy_engine_pkg::cp_state_t;
    import dmem_copy_engine_pkg::CP_IDLE;
    import dmem_copy_engine_pkg::CP_RD;
    import dmem_copy_engine_pkg::CP_WR;
    import dmem_copy_engine_pkg::CP_DONE;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = dmem_copy_engine_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              gnt,
    output logic              busy,
    output logic              done,
`ifdef DMEM_COPY_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);

    cp_state_t         state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CP_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            buf_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            buf_q   <= buf_d;
            busy_q  <= (state_d != CP_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        buf_d   = buf_q;
        unique case (state_q)
            CP_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    i_d     = '0;
                    state_d = (len == '0) ? CP_DONE : CP_RD;
                end
            end
            CP_RD: begin
                if (gnt) begin
                    buf_d   = mem_rd;
                    state_d = CP_WR;
                end
            end
            CP_WR: begin
                if (gnt) begin
                    i_d     = i_q + ADDR_W'(1);
                    state_d = (i_d == len_q) ? CP_DONE : CP_RD;
                end
            end
            CP_DONE: state_d = CP_IDLE;
            default: state_d = CP_IDLE;
        endcase
    end

    // Port drive decodes from registered state; only we sees gnt directly.
    always_comb begin
        mem_a  = '0;
        mem_wd = '0;
        mem_we = 1'b0;
        unique case (state_q)
            CP_RD: mem_a = src_q + i_q;
            CP_WR: begin
                mem_a  = dst_q + i_q;
                mem_wd = buf_q;
                mem_we = gnt;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = (state_q == CP_DONE);

`ifdef DMEM_COPY_CSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (state_q == CP_IDLE && start) begin
            csum <= '0;
        end else if (mem_we) begin
            csum <= csum + buf_q;
        end
    end
`endif

endmodule
